// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register and write-back datapath.
// Extracts and extends sub-word loads (big-endian byte order), chooses load
// data or the ALU result, suppresses writes to $0 and misaligned loads, and
// keeps a sticky misaligned-load flag.
// Optional feature macro: WB_RETIRE_CNT_EN adds the Retire_Count output.
module writeback_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              Stall,
   input  logic              Flush,
   input  logic              M_Valid,
   input  logic              M_RegWrite,
   input  logic              M_MemToReg,
   input  logic [REG_AW-1:0] M_rDest,
   input  logic [DATA_W-1:0] M_ALUResult,
   input  logic [DATA_W-1:0] M_MemReadData,
   input  logic [1:0]        M_R_Width,
   input  logic              M_LoadSigned,
   output logic              RegWrite,
   output logic [REG_AW-1:0] rDestSelected,
   output logic [DATA_W-1:0] regWriteData,
   output logic              WB_Valid,
   output logic              Misalign_Err
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [31:0]       Retire_Count
`endif
);

   localparam logic [1:0] WIDTH_HALF = 2'b01;
   localparam logic [1:0] WIDTH_BYTE = 2'b10;

   logic              valid_q, valid_d;
   logic              reg_write_q, reg_write_d;
   logic [REG_AW-1:0] rdest_q, rdest_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              misalign_q, misalign_d;

   logic [1:0]        off;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [DATA_W-1:0] load_data;
   logic              misaligned;

   // Load lane selection, extension and misalignment detection.
   always_comb begin
      off = M_ALUResult[1:0];
      case (off)
         2'd0:    byte_sel = M_MemReadData[31:24];
         2'd1:    byte_sel = M_MemReadData[23:16];
         2'd2:    byte_sel = M_MemReadData[15:8];
         default: byte_sel = M_MemReadData[7:0];
      endcase
      half_sel = off[1] ? M_MemReadData[15:0] : M_MemReadData[31:16];
      case (M_R_Width)
         WIDTH_BYTE: begin
            load_data  = {{24{M_LoadSigned & byte_sel[7]}}, byte_sel};
            misaligned = 1'b0;
         end
         WIDTH_HALF: begin
            load_data  = {{16{M_LoadSigned & half_sel[15]}}, half_sel};
            misaligned = off[0];
         end
         // word and the reserved encoding both take the raw word
         default: begin
            load_data  = M_MemReadData;
            misaligned = (off != 2'd0);
         end
      endcase
      misaligned = misaligned & M_Valid & M_MemToReg;
   end

   // Next-state: stall holds everything, flush inserts a bubble, else capture.
   always_comb begin
      valid_d     = valid_q;
      reg_write_d = reg_write_q;
      rdest_d     = rdest_q;
      data_d      = data_q;
      misalign_d  = misalign_q;
      if (!Stall) begin
         if (Flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
         end else begin
            valid_d     = M_Valid;
            reg_write_d = M_Valid & M_RegWrite & (M_rDest != '0) & ~misaligned;
            rdest_d     = M_rDest;
            data_d      = M_MemToReg ? load_data : M_ALUResult;
            misalign_d  = misalign_q | misaligned;
         end
      end
   end

   // WB pipeline register.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         rdest_q     <= '0;
         data_q      <= '0;
         misalign_q  <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         reg_write_q <= reg_write_d;
         rdest_q     <= rdest_d;
         data_q      <= data_d;
         misalign_q  <= misalign_d;
      end
   end

`ifdef WB_RETIRE_CNT_EN
   logic [31:0] retire_q, retire_d;

   // Retired-instruction count; wraps silently.
   always_comb begin
      retire_d = retire_q;
      if (!Stall && !Flush && M_Valid) retire_d = retire_q + 32'd1;
   end

   // Retire counter register.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) retire_q <= '0;
      else          retire_q <= retire_d;
   end

   assign Retire_Count = retire_q;
`endif

   assign WB_Valid      = valid_q;
   assign RegWrite      = reg_write_q;
   assign rDestSelected = rdest_q;
   assign regWriteData  = data_q;
   assign Misalign_Err  = misalign_q;

endmodule
